// File: rtl/data_write_buffer_pkg.sv
// Shared types and default sizing for the data write buffer slice.
package data_write_buffer_pkg;

  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned AW_DEF    = 32;
  localparam int unsigned DW_DEF    = 32;

  typedef enum logic {
    RUN_ST   = 1'b0,
    FLUSH_ST = 1'b1
  } state_t;

endpackage

// File: rtl/data_write_buffer_if.sv
// Core data port plus memory write/read port of the write buffer.
interface data_write_buffer_if #(
  parameter int unsigned AW = data_write_buffer_pkg::AW_DEF,
  parameter int unsigned DW = data_write_buffer_pkg::DW_DEF
);

  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_fence;
  logic          cpu_stall;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;

  // Buffer-side view
  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, cpu_fence, mem_rdata, mem_wready,
    output cpu_rdata, cpu_stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata
  );

  // Core/memory environment view
  modport master (
    output cpu_we, cpu_addr, cpu_wdata, cpu_fence, mem_rdata, mem_wready,
    input  cpu_rdata, cpu_stall, mem_raddr, mem_wvalid, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/data_write_buffer_wb_fifo.sv
// Circular store buffer: push at tail, pop at head, per-entry valid, full read-out.
module wb_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned AW    = 32,
  parameter  int unsigned DW    = 32,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic [PW-1:0] o_tail,
  output logic [PW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic [DEPTH-1:0] o_valid,
  output logic [AW-1:0] o_addr_all [DEPTH],
  output logic [DW-1:0] o_data_all [DEPTH]
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;

  // Entry payload storage; needs no reset since r_valid qualifies it
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_addr;
      r_data[r_tail] <= i_data;
    end
  end

  // Pointers, occupancy and per-entry valid flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_pop) begin
        r_head          <= r_head + PW'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (i_push) begin
        r_tail          <= r_tail + PW'(1);
        r_valid[r_tail] <= 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];
  assign o_tail      = r_tail;
  assign o_count     = r_count;
  assign o_full      = (r_count == FULL_CNT);
  assign o_empty     = (r_count == '0);
  assign o_valid     = r_valid;
  assign o_addr_all  = r_addr;
  assign o_data_all  = r_data;

endmodule

// File: rtl/data_write_buffer.sv
// Posted-write buffer between the core data port and data memory, with
// store-to-load forwarding and fence drain.
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic clk,
  input  logic reset,
  data_write_buffer_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_stall;
  logic             w_full;
  logic             w_empty;
  logic             w_drain_done;
  logic [PW:0]      w_count;
  logic [PW-1:0]    w_tail;
  logic [PW-1:0]    w_idx;
  logic             w_hit;
  logic [DW-1:0]    w_fwd;
  logic [AW-1:0]    w_head_addr;
  logic [DW-1:0]    w_head_data;
  logic [DEPTH-1:0] w_valid;
  logic [AW-1:0]    w_addr_all [DEPTH];
  logic [DW-1:0]    w_data_all [DEPTH];

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_addr      (bus.cpu_addr),
    .i_data      (bus.cpu_wdata),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_tail      (w_tail),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_valid     (w_valid),
    .o_addr_all  (w_addr_all),
    .o_data_all  (w_data_all)
  );

  assign w_stall = (bus.cpu_we && w_full) || (r_state == FLUSH_ST) ||
                   (bus.cpu_fence && !w_empty);
  assign w_push  = bus.cpu_we && !w_stall;
  assign w_pop   = !w_empty && bus.mem_wready;
  // Occupancy reaches zero at this edge (pushes cannot occur while stalled)
  assign w_drain_done = (w_count == (PW+1)'(1)) && w_pop && !w_push;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN_ST;
    else       r_state <= w_state_nxt;
  end

  // Next state: a fence whose last entry retires on the same edge never
  // enters FLUSH, so the stall still drops exactly one cycle after the last pop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN_ST:   if (bus.cpu_fence && !w_empty && !w_drain_done) w_state_nxt = FLUSH_ST;
      FLUSH_ST: if (w_drain_done || w_empty) w_state_nxt = RUN_ST;
      default:  w_state_nxt = RUN_ST;
    endcase
  end

  // Newest-match forwarding: walk from tail-1 back toward head
  always_comb begin
    w_hit = 1'b0;
    w_fwd = bus.mem_rdata;
    w_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = w_tail - PW'(k + 1);
      if (!w_hit && w_valid[w_idx] &&
          (w_addr_all[w_idx][AW-1:2] == bus.cpu_addr[AW-1:2])) begin
        w_hit = 1'b1;
        w_fwd = w_data_all[w_idx];
      end
    end
  end

  assign bus.cpu_rdata  = w_fwd;
  assign bus.cpu_stall  = w_stall;
  assign bus.mem_raddr  = bus.cpu_addr;
  assign bus.mem_wvalid = !w_empty;
  assign bus.mem_waddr  = w_head_addr;
  assign bus.mem_wdata  = w_head_data;

endmodule

// File: tb/tb_data_write_buffer.sv
// Self-checking bench for data_write_buffer against a queue-based model.
module tb_data_write_buffer;
  import data_write_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam logic [31:0] MEM_KEY = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_write_buffer_if #(.AW(AW), .DW(DW)) bus ();
  assign bus.mem_rdata = bus.mem_raddr ^ MEM_KEY;

  data_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_flush;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rdata(input logic [31:0] addr);
    for (int i = int'(q.size()) - 1; i >= 0; i--)
      if (q[i].a[31:2] == addr[31:2]) return q[i].d;
    return addr ^ MEM_KEY;
  endfunction

  // One clock cycle: drive, check outputs mid-cycle, update the model at the edge
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic f, input logic rdy,
                      output bit stalled, output logic [31:0] rd);
    bit   exp_stall;
    int   sz;
    ent_t e;
    bus.cpu_we     = we;
    bus.cpu_addr   = a;
    bus.cpu_wdata  = d;
    bus.cpu_fence  = f;
    bus.mem_wready = rdy;
    @(negedge clk);
    sz        = q.size();
    exp_stall = (we && sz == DEPTH) || m_flush || (f && sz != 0);
    chk("stall", bus.cpu_stall, exp_stall);
    chk("wvalid", bus.mem_wvalid, sz != 0);
    if (sz != 0) begin
      chk("waddr", bus.mem_waddr, q[0].a);
      chk("wdata", bus.mem_wdata, q[0].d);
    end
    chk("rdata", bus.cpu_rdata, mdl_rdata(a));
    stalled = exp_stall;
    rd      = bus.cpu_rdata;
    @(posedge clk);
    if (sz != 0 && rdy) void'(q.pop_front());
    if (we && !exp_stall) begin
      e.a = a;
      e.d = d;
      q.push_back(e);
    end
    if (q.size() == 0)       m_flush = 1'b0;
    else if (f && sz != 0)   m_flush = 1'b1;
    #1;
  endtask

  task automatic drain();
    bit          s;
    logic [31:0] r;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 32'h0, 32'h0, 0, 1, s, r);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit          s;
    logic [31:0] r;
    int          nst;
    logic        we, f;
    logic [31:0] a, d;

    n_tests = 0; n_fail = 0; m_flush = 0;
    bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_fence = 0; bus.mem_wready = 0;
    reset = 1'b1;
    #12;
    chk("rst_wvalid", bus.mem_wvalid, 0);
    chk("rst_stall", bus.cpu_stall, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Posted write
    step(1, 32'h10, 32'hAAAA_0001, 0, 1, s, r);
    chk("post_nostall", s, 0);
    step(0, 32'h0, 32'h0, 0, 1, s, r);
    step(0, 32'h0, 32'h0, 0, 1, s, r);
    chk("post_empty", bus.mem_wvalid, 0);

    // Full stall, wrap-around (pointers start at 1)
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 4*i, 32'hB000 + i, 0, 0, s, r);
    step(1, 32'h200, 32'hB004, 0, 0, s, r);
    chk("full_stall", s, 1);
    step(1, 32'h200, 32'hB004, 0, 1, s, r);
    chk("full_pop_stall", s, 1);
    step(1, 32'h200, 32'hB004, 0, 0, s, r);
    chk("full_accept", s, 0);
    drain();

    // Forwarding
    step(1, 32'h20, 32'h1, 0, 0, s, r);
    step(1, 32'h20, 32'h2, 0, 0, s, r);
    step(0, 32'h20, 32'h0, 0, 0, s, r);
    chk("fwd_20", r, 32'h2);
    step(0, 32'h24, 32'h0, 0, 0, s, r);
    chk("fwd_24_mem", r, 32'h24 ^ MEM_KEY);
    step(0, 32'h22, 32'h0, 0, 0, s, r);
    chk("fwd_22_word", r, 32'h2);
    drain();

    // Fence with 3 entries, memory ready toggling; store attempt held during flush
    for (int i = 0; i < 3; i++) step(1, 32'h300 + 4*i, 32'hC000 + i, 0, 0, s, r);
    nst = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 32'h40, 32'h77, 1, (i % 2 == 0), s, r);
      if (!s) break;
      nst++;
    end
    chk("fence_len", nst, 5);
    drain();
    step(0, 32'h0, 32'h0, 1, 0, s, r);
    chk("fence_empty", s, 0);

    // Simultaneous push and pop at count=2
    step(1, 32'h500, 32'hD000, 0, 0, s, r);
    step(1, 32'h504, 32'hD001, 0, 0, s, r);
    for (int i = 0; i < 10; i++) step(1, 32'h508 + 4*i, 32'hD002 + i, 0, 1, s, r);
    chk("simul_count", q.size(), 2);
    drain();

    // Randomized traffic; the core holds its request while stalled
    s = 0; we = 0; a = '0; d = '0; f = 0;
    for (int i = 0; i < 400; i++) begin
      if (!s) begin
        we = ($urandom_range(0, 1) == 1);
        a  = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        d  = $urandom;
        f  = ($urandom_range(0, 9) == 0);
      end
      step(we, a, d, f, ($urandom_range(0, 9) < 6), s, r);
    end
    drain();

    // Reset mid-drain with 3 entries
    for (int i = 0; i < 3; i++) step(1, 32'h600 + 4*i, 32'hE000 + i, 0, 0, s, r);
    step(0, 32'h0, 32'h0, 1, 0, s, r);
    bus.cpu_fence = 1; bus.mem_wready = 1;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_wvalid", bus.mem_wvalid, 0);
    chk("rst_mid_stall", bus.cpu_stall, 0);
    q.delete();
    m_flush = 0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 0, 1, s, r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
